// File: rtl/data_register.sv
// ---------------------------------------------------------------------------
// data_register
//   General-purpose clocked holding register for the stack-processor datapath
//   (PC, IR, ALU-out, stack pointer). Captures w_data on a rising clk edge
//   when regWrite is high, otherwise holds. r_data comes straight from the
//   storage flops, so there is no combinational path from any input.
//
// Ports
//   clk       in   1      system clock, rising edge
//   reset     in   1      synchronous, active-high; has priority over writes
//   regWrite  in   1      write enable
//   w_data    in   WIDTH  write data
//   r_data    out  WIDTH  stored value
// ---------------------------------------------------------------------------
module data_register #(
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned RESET_VALUE = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             regWrite,
   input  logic [WIDTH-1:0] w_data,
   output logic [WIDTH-1:0] r_data
);

   localparam logic [WIDTH-1:0] RST_VAL = WIDTH'(RESET_VALUE);

   // Declaration initialiser gives a defined power-up value before any reset.
   logic [WIDTH-1:0] data_q = RST_VAL;

   // Storage: reset wins over write. A floating (Z/X) reset does not compare
   // equal to 1, so it falls through to the normal write/hold path.
   always_ff @(posedge clk) begin
      if (reset == 1'b1) begin
         data_q <= RST_VAL;
      end else if (regWrite == 1'b1) begin
         data_q <= w_data;
      end
   end

   assign r_data = data_q;

endmodule

// File: tb/tb_data_register.sv
module tb_data_register;

   localparam int unsigned W = 16;

   logic         clk = 1'b0;
   logic         reset;
   logic         regWrite;
   logic [W-1:0] w_data;
   logic [W-1:0] r_data;

   int n_cmp = 0;
   int n_bad = 0;

   logic [W-1:0] exp_q[$];

   typedef struct {
      logic         rst;
      logic         we;
      logic [W-1:0] d;
      logic [W-1:0] exp;
      string        name;
   } vec_t;

   vec_t vecs[$];

   data_register #(.WIDTH(W), .RESET_VALUE(0)) dut (
      .clk      (clk),
      .reset    (reset),
      .regWrite (regWrite),
      .w_data   (w_data),
      .r_data   (r_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one vector on the falling edge, push its expectation, then pop and
   // compare just after the rising edge that samples it.
   task automatic apply(input logic rst, input logic we, input logic [W-1:0] d,
                        input logic [W-1:0] exp, input string name);
      logic [W-1:0] e;
      @(negedge clk);
      reset    = rst;
      regWrite = we;
      w_data   = d;
      exp_q.push_back(exp);
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         e = exp_q.pop_front();
         check(name, r_data, e);
      end
   endtask

   initial begin
      reset    = 1'b0;
      regWrite = 1'b0;
      w_data   = '0;

      // Power-up value before any reset or write.
      #1;
      check("powerup", r_data, 16'h0000);

      vecs.push_back('{1'b1, 1'b0, 16'h0000, 16'h0000, "reset"});
      vecs.push_back('{1'b0, 1'b1, 16'h0001, 16'h0001, "write_1"});
      vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0001, "hold_1"});
      vecs.push_back('{1'b0, 1'b1, 16'h0100, 16'h0100, "write_256"});
      vecs.push_back('{1'b0, 1'b0, 16'h0000, 16'h0100, "hold_256"});
      vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "write_ffff"});
      vecs.push_back('{1'b0, 1'b1, 16'h1234, 16'h1234, "write_1234"});
      vecs.push_back('{1'b0, 1'b0, 16'hABCD, 16'h1234, "hold_a"});
      vecs.push_back('{1'b0, 1'b0, 16'hABCD, 16'h1234, "hold_b"});
      vecs.push_back('{1'b0, 1'b0, 16'hABCD, 16'h1234, "hold_c"});
      vecs.push_back('{1'b0, 1'b1, 16'hFFFF, 16'hFFFF, "write_ffff2"});
      vecs.push_back('{1'b1, 1'b1, 16'h5555, 16'h0000, "reset_prio"});
      vecs.push_back('{1'b0, 1'b1, 16'h5555, 16'h5555, "post_reset_wr"});
      vecs.push_back('{1'b0, 1'b1, 16'h5555, 16'h5555, "repeat_wr"});
      vecs.push_back('{1'b0, 1'b1, 16'h8000, 16'h8000, "msb_only"});
      vecs.push_back('{1'b0, 1'b1, 16'hA5A5, 16'hA5A5, "pattern_a5"});
      vecs.push_back('{1'b0, 1'b1, 16'h5A5A, 16'h5A5A, "pattern_5a"});

      foreach (vecs[i])
         apply(vecs[i].rst, vecs[i].we, vecs[i].d, vecs[i].exp, vecs[i].name);

      // No combinational path: wiggle w_data with regWrite high and clk low.
      @(negedge clk);
      reset    = 1'b0;
      regWrite = 1'b1;
      w_data   = 16'h0F0F;
      #1;
      check("nocomb_a", r_data, 16'h5A5A);
      w_data = 16'hF0F0;
      #1;
      check("nocomb_b", r_data, 16'h5A5A);
      w_data = 16'h1357;
      #1;
      check("nocomb_c", r_data, 16'h5A5A);
      @(posedge clk);
      #1;
      check("nocomb_capture", r_data, 16'h1357);

      // regWrite dropped in the low phase right after the write edge.
      @(negedge clk);
      regWrite = 1'b0;
      w_data   = 16'h2468;
      @(posedge clk);
      #1;
      check("drop_after_write", r_data, 16'h1357);

      // Reset alone, then a write on the next edge.
      apply(1'b1, 1'b0, 16'h7777, 16'h0000, "reset_again");
      apply(1'b0, 1'b1, 16'h7777, 16'h7777, "first_after_reset");

      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL scoreboard_drain: %0d left, expected 0", exp_q.size());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
